// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port RAM between instruction
// fetch (IF) and load/store (LS). LS has fixed priority, but IF is forced to win
// after STARVE_MAX consecutive denials. One transaction is in flight at a time.
// Read data is steered back to whichever port owns the outstanding access.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 3;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_LAT);
  localparam logic [SW-1:0]    SMAX = SW'(STARVE_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_ls_q, owner_ls_d;
  logic              we_q, we_d;

  logic              resp;
  logic              issue_ok;
  logic              if_win;
  logic              ls_win;

  // The response cycle is the WAIT cycle in which the latency count completes;
  // a new access may be issued in that same cycle. Nothing is issued in reset.
  assign resp     = !RST && (state_q == WAIT) && (cnt_q == LAT);
  assign issue_ok = !RST && ((state_q == IDLE) || resp);
  assign if_win   = issue_ok && if_req && ((starve_q == SMAX) || !ls_req);
  assign ls_win   = issue_ok && ls_req && !if_win;

  // State register: FSM, latency counter, starvation counter and owner.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      owner_ls_q <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      owner_ls_q <= owner_ls_d;
      we_q       <= we_d;
    end
  end

  // Next-state logic: issue restarts the latency count, idle issue slots fall to IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_ls_d = owner_ls_q;
    we_d       = we_q;
    starve_d   = starve_q;

    if (issue_ok) begin
      if (if_win || ls_win) begin
        state_d    = WAIT;
        cnt_d      = CNT_W'(1);
        owner_ls_d = ls_win;
        we_d       = ls_win && ls_we;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // IF loses only when it is actually asking; any IF grant or idle IF resets it.
    if (!if_req || if_win) begin
      starve_d = '0;
    end else if (ls_win && (starve_q != SMAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Output logic: Mealy grants and RAM strobes, response routed to the owner.
  always_comb begin
    if_gnt    = if_win;
    ls_gnt    = ls_win;
    mem_en    = if_win || ls_win;
    mem_we    = ls_win && ls_we;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_win) begin
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_win) begin
      mem_be    = {BE_W{1'b1}};
      mem_addr  = if_addr;
    end

    if_rvalid = resp && !owner_ls_q;
    ls_rvalid = resp && owner_ls_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each
// with its own behavioural RAM, driven by directed steps and then random
// traffic, every output checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int SMAX = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          ls_req    [2];
  logic          ls_we     [2];
  logic [BW-1:0] ls_be     [2];
  logic [AW-1:0] ls_addr   [2];
  logic [DW-1:0] ls_wdata  [2];
  logic          if_gnt    [2];
  logic          if_rvalid [2];
  logic [DW-1:0] if_rdata  [2];
  logic          ls_gnt    [2];
  logic          ls_rvalid [2];
  logic [DW-1:0] ls_rdata  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [BW-1:0] mem_be    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0), .STARVE_MAX(SMAX)) u0 (
    .CLOCK_50(clk), .RST(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_be(ls_be[0]), .ls_addr(ls_addr[0]),
    .ls_wdata(ls_wdata[0]), .ls_gnt(ls_gnt[0]), .ls_rvalid(ls_rvalid[0]), .ls_rdata(ls_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) u1 (
    .CLOCK_50(clk), .RST(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_be(ls_be[1]), .ls_addr(ls_addr[1]),
    .ls_wdata(ls_wdata[1]), .ls_gnt(ls_gnt[1]), .ls_rvalid(ls_rvalid[1]), .ls_rdata(ls_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic logic [31:0] init_word(int k);
    return {8'hA5, 8'(k), 8'(k * 3), 8'(~k)};
  endfunction

  // Behavioural single-port RAMs with a MEM_LAT-deep read pipeline; non-read
  // cycles push random junk so that unqualified read data is visible.
  logic          init_ram;
  logic [DW-1:0] ram   [2][256];
  logic [DW-1:0] rpipe [2][4];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (init_ram) begin
        for (int k = 0; k < 256; k++) ram[i][k] <= init_word(k);
      end else if (mem_en[i] && mem_we[i]) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[i][b]) ram[i][mem_addr[i][9:2]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
      end
      rpipe[i][0] <= (mem_en[i] && !mem_we[i]) ? ram[i][mem_addr[i][9:2]] : $urandom;
      for (int k = 1; k < 4; k++) rpipe[i][k] <= rpipe[i][k-1];
    end
  end

  assign mem_rdata[0] = rpipe[0][LAT0-1];
  assign mem_rdata[1] = rpipe[1][LAT1-1];

  // Transaction-level reference model state.
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          lat_of   [2];
  bit          m_pend   [2];
  int          m_resp   [2];
  bit          m_own_ls [2];
  bit          m_we     [2];
  logic [31:0] m_dat    [2];
  int          m_starve [2];
  logic [31:0] m_mem    [2][256];
  bit          last_if_gnt [2];
  bit          last_ls_gnt [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int i);
    bit          resp, ok, iw, lw;
    bit          e_ifg, e_ifv, e_lsg, e_lsv, e_en, e_we;
    logic [31:0] e_ifd, e_lsd, e_addr, e_wd;
    logic [3:0]  e_be;
    logic [7:0]  idx;
    resp = 0; ok = 0; iw = 0; lw = 0;
    e_ifg = 0; e_ifv = 0; e_lsg = 0; e_lsv = 0; e_en = 0; e_we = 0;
    e_ifd = '0; e_lsd = '0; e_addr = '0; e_wd = '0; e_be = '0;

    if (!rst[i]) begin
      resp = m_pend[i] && (cyc == m_resp[i]);
      if (resp) begin
        if (m_own_ls[i]) begin
          e_lsv = 1;
          e_lsd = m_we[i] ? 32'h0 : m_dat[i];
        end else begin
          e_ifv = 1;
          e_ifd = m_dat[i];
        end
      end
      ok = !m_pend[i] || resp;
      iw = ok && if_req[i] && ((m_starve[i] == SMAX) || !ls_req[i]);
      lw = ok && ls_req[i] && !iw;
      if (iw) begin
        e_ifg = 1; e_en = 1; e_be = 4'hF; e_addr = if_addr[i];
      end
      if (lw) begin
        e_lsg = 1; e_en = 1; e_we = ls_we[i]; e_be = ls_be[i];
        e_addr = ls_addr[i]; e_wd = ls_wdata[i];
      end
    end

    chk($sformatf("if_gnt%0d", i),    if_gnt[i],    e_ifg);
    chk($sformatf("ls_gnt%0d", i),    ls_gnt[i],    e_lsg);
    chk($sformatf("if_rvalid%0d", i), if_rvalid[i], e_ifv);
    chk($sformatf("ls_rvalid%0d", i), ls_rvalid[i], e_lsv);
    chk($sformatf("if_rdata%0d", i),  if_rdata[i],  e_ifd);
    chk($sformatf("ls_rdata%0d", i),  ls_rdata[i],  e_lsd);
    chk($sformatf("mem_en%0d", i),    mem_en[i],    e_en);
    if (rst[i] || e_en) begin
      chk($sformatf("mem_we%0d", i),   mem_we[i],   e_we);
      chk($sformatf("mem_be%0d", i),   mem_be[i],   e_be);
      chk($sformatf("mem_addr%0d", i), mem_addr[i], e_addr);
    end
    if (rst[i] || lw) chk($sformatf("mem_wdata%0d", i), mem_wdata[i], e_wd);

    if (rst[i]) begin
      m_pend[i]   = 0;
      m_starve[i] = 0;
    end else begin
      if (resp) m_pend[i] = 0;
      if (iw || lw) begin
        m_pend[i]   = 1;
        m_resp[i]   = cyc + lat_of[i];
        m_own_ls[i] = lw;
        m_we[i]     = lw && ls_we[i];
        idx         = e_addr[9:2];
        if (m_we[i]) begin
          m_dat[i] = '0;
          for (int b = 0; b < 4; b++)
            if (e_be[b]) m_mem[i][idx][8*b +: 8] = e_wd[8*b +: 8];
        end else begin
          m_dat[i] = m_mem[i][idx];
        end
      end
      if (!if_req[i] || iw) m_starve[i] = 0;
      else if (lw && (m_starve[i] < SMAX)) m_starve[i] = m_starve[i] + 1;
    end
    last_if_gnt[i] = e_ifg;
    last_ls_gnt[i] = e_lsg;
  endtask

  // Inputs are applied at the falling edge; outputs are checked 1 ns later.
  task automatic tick();
    #1;
    model_step(0);
    model_step(1);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_if(int i, bit req, logic [31:0] addr);
    if_req[i]  = req;
    if_addr[i] = addr;
  endtask

  task automatic set_ls(int i, bit req, bit we, logic [3:0] be, logic [31:0] addr, logic [31:0] wd);
    ls_req[i]   = req;
    ls_we[i]    = we;
    ls_be[i]    = be;
    ls_addr[i]  = addr;
    ls_wdata[i] = wd;
  endtask

  logic [31:0] ramword;
  logic [31:0] initword;

  initial begin
    init_ram  = 1'b1;
    lat_of[0] = LAT0;
    lat_of[1] = LAT1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      set_if(i, 0, '0);
      set_ls(i, 0, 0, '0, '0, '0);
      m_pend[i] = 0; m_resp[i] = 0; m_own_ls[i] = 0; m_we[i] = 0;
      m_dat[i] = '0; m_starve[i] = 0;
      last_if_gnt[i] = 0; last_ls_gnt[i] = 0;
      for (int k = 0; k < 256; k++) m_mem[i][k] = init_word(k);
    end
    @(negedge clk);
    init_ram = 1'b0;

    // Reset state: everything quiet while reset is held.
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // Back-to-back IF reads at MEM_LAT=1.
    set_if(0, 1, 32'h00); tick();
    set_if(0, 1, 32'h04); tick();
    set_if(0, 1, 32'h08); tick();
    set_if(0, 0, 32'h00); tick();

    // Simultaneous requests: LS first, then IF.
    set_if(0, 1, 32'h10);
    set_ls(0, 1, 0, 4'hF, 32'h100, 32'h0); tick();
    set_ls(0, 0, 0, 4'h0, 32'h0, 32'h0);   tick();
    set_if(0, 0, 32'h0);                   tick();

    // Starvation: four LS wins, then IF forced through.
    set_if(0, 1, 32'h20);
    for (int n = 0; n < 6; n++) begin
      set_ls(0, 1, 0, 4'hF, 32'(32'h40 + 4 * n), 32'h0);
      tick();
    end
    set_if(0, 0, 32'h0);
    set_ls(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick();

    // Partial write, then read it back.
    set_ls(0, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF); tick();
    set_ls(0, 1, 0, 4'hF, 32'h200, 32'h0);            tick();
    set_ls(0, 0, 0, 4'h0, 32'h0, 32'h0);              tick();
    ramword  = ram[0][128];
    initword = init_word(128);
    chk("wr_lo", {16'h0, ramword[15:0]}, 32'h0000BEEF);
    chk("wr_hi", {16'h0, ramword[31:16]}, {16'h0, initword[31:16]});

    // MEM_LAT=3 continuous IF.
    set_if(1, 1, 32'h30);
    for (int n = 0; n < 7; n++) tick();
    set_if(1, 0, 32'h0);
    for (int n = 0; n < 3; n++) tick();

    // MEM_LAT=3 reset one cycle after issue.
    set_if(1, 1, 32'h44); tick();
    rst[1] = 1'b1;        tick();
    rst[1] = 1'b0;        tick();
    chk("rst_regnt_pend", 32'(m_pend[1]), 32'h1);
    set_if(1, 0, 32'h0);
    for (int n = 0; n < 5; n++) tick();

    // Random traffic with protocol-legal holds, aborts and occasional reset.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 99) == 0);
        if (if_req[i] && !last_if_gnt[i]) begin
          if ($urandom_range(0, 7) == 0) if_req[i] = 1'b0;
        end else begin
          set_if(i, 1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 255)), 2'b00});
        end
        if (ls_req[i] && !last_ls_gnt[i]) begin
          if ($urandom_range(0, 7) == 0) ls_req[i] = 1'b0;
        end else begin
          set_ls(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
                 {22'h0, 8'($urandom_range(0, 31)), 2'b00}, $urandom);
        end
      end
      tick();
    end

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      set_if(i, 0, '0);
      set_ls(i, 0, 0, '0, '0, '0);
    end
    for (int n = 0; n < 5; n++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
